// File: rtl/bufer_write_ctrl_pkg.sv
// bufer_write_ctrl_pkg
//   Shared definitions for the ping-pong frame buffer write side. These
//   constants take the place of the old define.v:
//     FSMC_WIDTH     - width of a buffer word
//     DATA_READ_RAZR - width of a buffer address
//     LENTH_BUFER    - buffer depth, equal to 2**DATA_READ_RAZR
//   It also holds the writer state encodings.
package bufer_write_ctrl_pkg;

  localparam int FSMC_WIDTH     = 16;
  localparam int DATA_READ_RAZR = 8;
  localparam int LENTH_BUFER    = 1 << DATA_READ_RAZR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } wr_state_t;

endpackage

// File: rtl/bufer_write_ctrl.sv
// bufer_write_ctrl
//   Write-side controller for the ping-pong frame buffer. It takes a stream of
//   words with a valid strobe and turns it into buffer write strobes,
//   addresses and data. When a frame is complete, it swaps banks and signals
//   the FSMC reader. If the reader still owns the previous bank, the controller
//   drops incoming words and sets a sticky overflow flag.
//
// Ports
//   CLK, RESET    clock; asynchronous active-high reset
//   start_write   level; 1 enables capture, 0 stops or aborts
//   FRAME_LEN     words per frame, latched when capture starts (0 = 2**ADDR_W)
//   DIN_VALID/DIN input stream, one word per cycle
//   RD_DONE       one-cycle pulse from the reader: its bank has been drained
//   BUFER_IN_EN   buffer write strobe (one cycle per accepted word)
//   NUMB_BYTE_IN  buffer write address
//   DATA_OUT      buffer write data
//   BUFER_CHANGE  bank select; the writer fills the bank opposite the reader
//   FRAME_READY   a full bank is waiting for the reader
//   OVERFLOW      sticky: a word was dropped while holding
//   FRAME_CNT     completed frames (wraps)
//   BUSY          controller is not idle
module bufer_write_ctrl
  import bufer_write_ctrl_pkg::*;
#(
  parameter int DATA_W = FSMC_WIDTH,
  parameter int ADDR_W = DATA_READ_RAZR,
  parameter int CNT_W  = 16
)(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] FRAME_LEN,
  input  logic              DIN_VALID,
  input  logic [DATA_W-1:0] DIN,
  input  logic              RD_DONE,
  output logic              BUFER_IN_EN,
  output logic [ADDR_W-1:0] NUMB_BYTE_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              BUFER_CHANGE,
  output logic              FRAME_READY,
  output logic              OVERFLOW,
  output logic [CNT_W-1:0]  FRAME_CNT,
  output logic              BUSY
);

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_last_idx;
  logic              r_swap_pend;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_bank;
  logic              r_ready;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;

  // A completed frame may be handed over if the reader holds nothing, or if
  // it releases its bank at the same edge as the swap.
  logic w_swap_ok;
  logic w_last;
  assign w_swap_ok = !r_ready || RD_DONE;
  assign w_last    = (r_wr_ptr == r_last_idx);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_last_idx  <= '0;
      r_swap_pend <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_bank      <= 1'b0;
      r_ready     <= 1'b0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_wr_en <= 1'b0;
      // The reader releases its bank. A swap at this edge assigns r_ready
      // later in the block, so the set has priority over this clear.
      if (RD_DONE) r_ready <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start_write) begin
            r_state     <= ST_FILL;
            r_last_idx  <= FRAME_LEN - 1'b1;  // FRAME_LEN=0 wraps to all-ones
            r_wr_ptr    <= '0;
            r_ovf       <= 1'b0;
            r_swap_pend <= 1'b0;
          end
        end

        ST_FILL: begin
          // The swap happens one edge after the last word is accepted, so
          // that word's strobe still targets the old bank.
          if (r_swap_pend && w_swap_ok) begin
            r_bank  <= ~r_bank;
            r_ready <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
          end

          if (r_swap_pend && !w_swap_ok) begin
            // The reader still owns the other bank. Park the full frame and
            // drop words until the reader releases it.
            r_swap_pend <= 1'b0;
            if (!start_write) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_HOLD;
              if (DIN_VALID) r_ovf <= 1'b1;
            end
          end else begin
            r_swap_pend <= 1'b0;
            if (DIN_VALID) begin
              r_wr_en <= 1'b1;
              r_addr  <= r_wr_ptr;
              r_data  <= DIN;
              if (w_last) begin
                r_wr_ptr    <= '0;
                r_swap_pend <= 1'b1;
              end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
              end
            end
            // Abort: the word above is still written, but the partial frame
            // is discarded and no swap is made.
            if (!start_write) begin
              r_state     <= ST_IDLE;
              r_wr_ptr    <= '0;
              r_swap_pend <= 1'b0;
            end
          end
        end

        ST_HOLD: begin
          if (DIN_VALID) r_ovf <= 1'b1;
          if (!start_write) begin
            // The full bank remains marked ready so the reader can drain it.
            r_state <= ST_IDLE;
          end else if (RD_DONE) begin
            r_bank   <= ~r_bank;
            r_ready  <= 1'b1;
            r_cnt    <= r_cnt + 1'b1;
            r_wr_ptr <= '0;
            r_state  <= ST_FILL;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign BUFER_IN_EN  = r_wr_en;
  assign NUMB_BYTE_IN = r_addr;
  assign DATA_OUT     = r_data;
  assign BUFER_CHANGE = r_bank;
  assign FRAME_READY  = r_ready;
  assign OVERFLOW     = r_ovf;
  assign FRAME_CNT    = r_cnt;
  assign BUSY         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bufer_write_ctrl.sv
// tb_bufer_write_ctrl
//   Directed testbench for bufer_write_ctrl. Each expected write
//   (address, data, bank) goes into a queue when the word is driven. A
//   monitor pops the queue and compares on every strobe.
module tb_bufer_write_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start_write = 1'b0;
  logic [7:0]  FRAME_LEN = '0;
  logic        DIN_VALID = 1'b0;
  logic [15:0] DIN = '0;
  logic        RD_DONE = 1'b0;
  logic        BUFER_IN_EN;
  logic [7:0]  NUMB_BYTE_IN;
  logic [15:0] DATA_OUT;
  logic        BUFER_CHANGE;
  logic        FRAME_READY;
  logic        OVERFLOW;
  logic [15:0] FRAME_CNT;
  logic        BUSY;

  bufer_write_ctrl #(.DATA_W(16), .ADDR_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .start_write(start_write), .FRAME_LEN(FRAME_LEN),
    .DIN_VALID(DIN_VALID), .DIN(DIN), .RD_DONE(RD_DONE),
    .BUFER_IN_EN(BUFER_IN_EN), .NUMB_BYTE_IN(NUMB_BYTE_IN), .DATA_OUT(DATA_OUT),
    .BUFER_CHANGE(BUFER_CHANGE), .FRAME_READY(FRAME_READY), .OVERFLOW(OVERFLOW),
    .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    logic        b;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // The buffer samples on the negedge, so the monitor compares there too.
  always @(negedge CLK) begin
    if (!RESET && BUFER_IN_EN === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(NUMB_BYTE_IN), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("write", 32'({NUMB_BYTE_IN, DATA_OUT, BUFER_CHANGE}), 32'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] a, input logic b);
    DIN_VALID = 1'b1;
    DIN       = d;
    sb.push_back('{a: a, d: d, b: b});
    tick();
    DIN_VALID = 1'b0;
  endtask

  task automatic drop(input logic [15:0] d);
    DIN_VALID = 1'b1;
    DIN       = d;
    tick();
    DIN_VALID = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_en",    32'(BUFER_IN_EN), 0);
    chk("rst_addr",  32'(NUMB_BYTE_IN), 0);
    chk("rst_data",  32'(DATA_OUT), 0);
    chk("rst_bank",  32'(BUFER_CHANGE), 0);
    chk("rst_ready", 32'(FRAME_READY), 0);
    chk("rst_cnt",   32'(FRAME_CNT), 0);
    chk("rst_busy",  32'(BUSY), 0);
    RESET = 1'b0;
    tick();

    // single frame, FRAME_LEN=4
    FRAME_LEN = 8'd4; start_write = 1'b1;
    tick();
    chk("busy_fill", 32'(BUSY), 1);
    for (int i = 0; i < 4; i++) send(16'hA0 + 16'(i), 8'(i), 1'b0);
    chk("f1_bank_before_swap", 32'(BUFER_CHANGE), 0);
    tick();
    chk("f1_bank", 32'(BUFER_CHANGE), 1);
    chk("f1_ready", 32'(FRAME_READY), 1);
    chk("f1_cnt", 32'(FRAME_CNT), 1);

    // second frame, reader releases mid-frame
    send(16'hB0, 8'd0, 1'b1);
    send(16'hB1, 8'd1, 1'b1);
    RD_DONE = 1'b1;
    send(16'hB2, 8'd2, 1'b1);
    RD_DONE = 1'b0;
    chk("f2_release", 32'(FRAME_READY), 0);
    send(16'hB3, 8'd3, 1'b1);
    tick();
    chk("f2_bank", 32'(BUFER_CHANGE), 0);
    chk("f2_cnt", 32'(FRAME_CNT), 2);
    chk("f2_ready", 32'(FRAME_READY), 1);
    chk("f2_ovf", 32'(OVERFLOW), 0);

    // third frame with no release: hold and overflow
    for (int i = 0; i < 4; i++) send(16'hC0 + 16'(i), 8'(i), 1'b0);
    drop(16'hD0); drop(16'hD1); drop(16'hD2);
    chk("hold_ovf", 32'(OVERFLOW), 1);
    chk("hold_bank", 32'(BUFER_CHANGE), 0);
    chk("hold_cnt", 32'(FRAME_CNT), 2);
    chk("hold_busy", 32'(BUSY), 1);
    RD_DONE = 1'b1;
    tick();
    RD_DONE = 1'b0;
    chk("hold_rel_bank", 32'(BUFER_CHANGE), 1);
    chk("hold_rel_cnt", 32'(FRAME_CNT), 3);
    chk("hold_rel_ready", 32'(FRAME_READY), 1);

    // resume at addr 0, then abort after 2 of 4 words
    send(16'hE0, 8'd0, 1'b1);
    send(16'hE1, 8'd1, 1'b1);
    start_write = 1'b0;
    tick();
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_cnt", 32'(FRAME_CNT), 3);
    chk("abort_bank", 32'(BUFER_CHANGE), 1);
    chk("abort_ready", 32'(FRAME_READY), 1);
    chk("abort_ovf_sticky", 32'(OVERFLOW), 1);

    // release coincides with the swap edge
    FRAME_LEN = 8'd2; start_write = 1'b1;
    tick();
    chk("restart_ovf_clr", 32'(OVERFLOW), 0);
    send(16'hF0, 8'd0, 1'b1);
    send(16'hF1, 8'd1, 1'b1);
    RD_DONE = 1'b1;
    tick();
    RD_DONE = 1'b0;
    chk("sim_ready", 32'(FRAME_READY), 1);
    chk("sim_bank", 32'(BUFER_CHANGE), 0);
    chk("sim_cnt", 32'(FRAME_CNT), 4);
    send(16'h00C0, 8'd0, 1'b0);  // would be dropped if the controller were holding
    start_write = 1'b0;
    tick();
    RD_DONE = 1'b1;
    tick();
    chk("idle_release", 32'(FRAME_READY), 0);
    tick();
    RD_DONE = 1'b0;
    chk("release_when_clear", 32'(FRAME_READY), 0);

    // FRAME_LEN=0 means a full 256-word frame
    FRAME_LEN = 8'd0; start_write = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) send(16'h1000 + 16'(i), 8'(i), 1'b0);
    chk("full_no_swap_yet", 32'(BUFER_CHANGE), 0);
    send(16'h2000, 8'd0, 1'b1);
    chk("full_bank", 32'(BUFER_CHANGE), 1);
    chk("full_cnt", 32'(FRAME_CNT), 5);
    chk("full_ready", 32'(FRAME_READY), 1);

    // asynchronous reset in the middle of a cycle
    send(16'h2001, 8'd1, 1'b1);
    @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    chk("arst_en",    32'(BUFER_IN_EN), 0);
    chk("arst_addr",  32'(NUMB_BYTE_IN), 0);
    chk("arst_data",  32'(DATA_OUT), 0);
    chk("arst_bank",  32'(BUFER_CHANGE), 0);
    chk("arst_ready", 32'(FRAME_READY), 0);
    chk("arst_ovf",   32'(OVERFLOW), 0);
    chk("arst_cnt",   32'(FRAME_CNT), 0);
    chk("arst_busy",  32'(BUSY), 0);
    tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bufer_write_ctrl.md
Name: bufer_write_ctrl

Overview:
Write-side controller for the ping-pong frame buffer. It accepts a stream of data words with a valid strobe and generates the buffer write strobe, the write address and the registered write data. When a frame is complete it toggles bank select and raises FRAME_READY toward the FSMC reader. It holds the stream when the reader has not yet released the previous bank.

Parameters:
DATA_W, 16, word width (equals FSMC_WIDTH)
ADDR_W, 8, buffer address width (equals DATA_READ_RAZR; buffer depth is 2**ADDR_W = LENTH_BUFER)
CNT_W, 16, width of the completed-frame counter

Ports:
CLK  in  1  single system clock; all logic on posedge
RESET  in  1  asynchronous, active-high reset
start_write  in  1  level; 1 = capture enabled, 0 = stop/abort
FRAME_LEN  in  ADDR_W  words per frame, sampled on entry to FILL; 0 means 2**ADDR_W
DIN_VALID  in  1  input word valid, one word per cycle
DIN  in  DATA_W  input word
RD_DONE  in  1  one-cycle pulse from reader: ready bank fully read
BUFER_IN_EN  out  1  buffer write strobe
NUMB_BYTE_IN  out  ADDR_W  buffer write address
DATA_OUT  out  DATA_W  buffer write data
BUFER_CHANGE  out  1  bank select; the writer fills the bank opposite the reader
FRAME_READY  out  1  a full bank is waiting for the reader
OVERFLOW  out  1  sticky: a word was dropped
FRAME_CNT  out  CNT_W  completed frames, wraps at 2**CNT_W
BUSY  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; wr_ptr=0; all outputs 0. BUFER_CHANGE=0, so the writer targets bufer2 and the reader targets bufer1.
- Outputs are registered. A word accepted at edge N appears on BUFER_IN_EN, NUMB_BYTE_IN and DATA_OUT during cycle N..N+1, giving 1-cycle latency. The buffer samples on the negedge inside that cycle.
- BUFER_IN_EN is high exactly one cycle per accepted word. NUMB_BYTE_IN and DATA_OUT hold their values while BUFER_IN_EN=0.
- last_idx = latched FRAME_LEN - 1, computed mod 2**ADDR_W, so FRAME_LEN=0 gives last_idx=all-ones.
- IDLE: DIN_VALID is ignored and OVERFLOW is not set. When start_write=1, go to FILL, latch FRAME_LEN, set wr_ptr=0 and clear OVERFLOW. Entry to FILL takes 1 cycle; DIN in that same cycle is ignored.
- FILL, DIN_VALID=1 and wr_ptr!=last_idx: write the word and increment wr_ptr.
- FILL, DIN_VALID=1 and wr_ptr==last_idx: write the word, set wr_ptr=0 and set swap_pend.
  - If FRAME_READY=0, or RD_DONE is asserted in the same cycle: at the next edge toggle BUFER_CHANGE, set FRAME_READY=1, increment FRAME_CNT and stay in FILL. The toggle occurs one edge after the last strobe, so the last word lands in the old bank.
  - Otherwise go to HOLD.
- HOLD: each DIN_VALID word is dropped (no strobe) and OVERFLOW is set to 1. When RD_DONE arrives: toggle BUFER_CHANGE, keep FRAME_READY at 1 (new frame), increment FRAME_CNT and go to FILL with wr_ptr=0.
- RD_DONE clears FRAME_READY when no swap happens in the same edge. If the reader releases at the same edge the writer swaps, the set wins and FRAME_READY stays 1. RD_DONE while FRAME_READY=0 is ignored.
- start_write=0 in FILL: go to IDLE next edge. A word valid in that same cycle is still written. The partial frame is discarded: no swap, wr_ptr=0.
- start_write=0 in HOLD: go to IDLE. FRAME_READY and BUFER_CHANGE keep their values, so the reader can still drain the full bank.
- FRAME_READY, BUFER_CHANGE and FRAME_CNT survive IDLE; only RESET clears them.
- Reset mid-frame: everything returns to reset values immediately, and the buffer contents are don't-care.

Decomposition:
- Shared define file (define.v) supplies FSMC_WIDTH, DATA_READ_RAZR and LENTH_BUFER, which become the parameter defaults.
- Add to define.v: the state encodings ST_IDLE=2'd0, ST_FILL=2'd1, ST_HOLD=2'd2.
- No sub-module. A single FSM with a pointer counter is the natural size. The existing bufer module is instantiated alongside in the top level, not inside this block.

Test Plan:
- Single frame: reset, FRAME_LEN=4, start_write=1, DIN 0xA0..0xA3 on consecutive cycles -> four strobes at addr 0..3 with matching data; BUFER_CHANGE 0->1 one edge after the last strobe; FRAME_READY=1; FRAME_CNT=1.
- Back-to-back with release: RD_DONE pulse mid-second-frame; frame 2 = 0xB0..0xB3 -> second swap (BUFER_CHANGE 1->0), FRAME_CNT=2, FRAME_READY=1, OVERFLOW=0.
- Hold/overflow: no RD_DONE after frame 1; frame 2 completes; 3 more valid words -> state HOLD, no strobes for the 3 words, OVERFLOW=1. RD_DONE -> BUFER_CHANGE toggles, FRAME_CNT=2, FILL resumes at addr 0.
- Simultaneous: RD_DONE on the same edge as the frame-2 swap -> FRAME_READY stays 1 and no HOLD entry.
- FRAME_LEN=0, ADDR_W=8: 256 words -> addresses 0..255, then swap; word 257 writes addr 0 of the other bank.
- Abort and reset: start_write=0 after 2 of 4 words -> IDLE, no swap, FRAME_CNT unchanged. Async RESET mid-FILL -> all outputs 0 without waiting for a clock edge.
